// File: rtl/prach_ant_buffer_if.sv
// prach_ant_buffer_if: sample-in, readout request and read-port bundle.
// Optional PRACH_ANT_BUFFER_OVF_CNT_EN adds the ovf_cnt output signal.
interface prach_ant_buffer_if #(
  parameter int HDR_W = 120
) ();
  logic [15:0]      din_dr;
  logic [15:0]      din_di;
  logic             din_dv;
  logic             sync_in;
  logic [HDR_W-1:0] hdr_in;
  logic [HDR_W-1:0] ap_hdr;
  logic             ap_req;
  logic             ap_ack;
  logic [10:0]      rd_addr;
  logic             rd_en;
  logic [31:0]      rd_data;
  logic             ovf;
`ifdef PRACH_ANT_BUFFER_OVF_CNT_EN
  logic [15:0]      ovf_cnt;

  modport master (
    output din_dr, din_di, din_dv, sync_in, hdr_in,
    output ap_ack, rd_addr, rd_en,
    input  ap_hdr, ap_req, rd_data, ovf, ovf_cnt
  );
  modport slave (
    input  din_dr, din_di, din_dv, sync_in, hdr_in,
    input  ap_ack, rd_addr, rd_en,
    output ap_hdr, ap_req, rd_data, ovf, ovf_cnt
  );
`else
  modport master (
    output din_dr, din_di, din_dv, sync_in, hdr_in,
    output ap_ack, rd_addr, rd_en,
    input  ap_hdr, ap_req, rd_data, ovf
  );
  modport slave (
    input  din_dr, din_di, din_dv, sync_in, hdr_in,
    input  ap_ack, rd_addr, rd_en,
    output ap_hdr, ap_req, rd_data, ovf
  );
`endif
endinterface

// File: rtl/prach_ant_buffer.sv
// prach_ant_buffer: ping-pong PRACH occasion buffer with 3-cycle read port.
// Optional PRACH_ANT_BUFFER_OVF_CNT_EN adds a saturating overflow counter.
module prach_ant_buffer #(
  parameter int LEN   = 1536,
  parameter int HDR_W = 120
) (
  input  logic               clk,
  input  logic               rst_n,
  prach_ant_buffer_if.slave  bus
);

  typedef enum logic [1:0] {
    B_FREE, B_FILL, B_FULL, B_READ
  } bst_t;

  typedef enum logic {
    S_IDLE, S_FILL
  } wst_t;

  wst_t             r_state;
  wst_t             w_state_nxt;
  bst_t             r_bst [2];
  logic             r_wr_bank;
  logic             r_fill_bank;
  logic             r_rd_bank;
  logic [10:0]      r_wr_cnt;
  logic [HDR_W-1:0] r_hdr [2];
  logic             r_ap_req;
  logic             r_busy;
  logic             r_ovf;

  logic [31:0]      r_mem [0:4095];
  logic [10:0]      r_raddr;
  logic             r_rbank;
  logic             r_ren1;
  logic             r_ren2;
  logic [31:0]      r_rdat;
  logic [31:0]      r_rd_data;

  logic             w_sync;
  logic             w_we;
  logic [10:0]      w_waddr;
  logic             w_bank;
  logic             w_claim;
  logic             w_done;
  logic             w_ovf;
  logic             w_ack_start;
  logic             w_ack_end;

  assign w_sync = bus.din_dv && bus.sync_in;

  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_waddr     = r_wr_cnt;
    w_bank      = r_fill_bank;
    w_claim     = 1'b0;
    w_done      = 1'b0;
    w_ovf       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_sync) begin
          if (r_bst[r_wr_bank] == B_FREE) begin
            w_claim = 1'b1;
            w_bank  = r_wr_bank;
          end else if (r_bst[~r_wr_bank] == B_FREE) begin
            w_claim = 1'b1;
            w_bank  = ~r_wr_bank;
          end else begin
            w_ovf = 1'b1;
          end
          if (w_claim) begin
            w_we        = 1'b1;
            w_waddr     = 11'd0;
            w_state_nxt = S_FILL;
          end
        end
      end
      S_FILL: begin
        // A new sync abandons the partial frame and restarts in place
        if (w_sync) begin
          w_claim = 1'b1;
          w_we    = 1'b1;
          w_waddr = 11'd0;
        end else if (bus.din_dv) begin
          w_we = 1'b1;
          if (r_wr_cnt == 11'(LEN - 1)) begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_ack_start = bus.ap_ack && r_ap_req && !r_busy;
  assign w_ack_end   = !bus.ap_ack && r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bst[0]    <= B_FREE;
      r_bst[1]    <= B_FREE;
      r_hdr[0]    <= '0;
      r_hdr[1]    <= '0;
      r_wr_bank   <= 1'b0;
      r_fill_bank <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_wr_cnt    <= 11'd0;
      r_ap_req    <= 1'b0;
      r_busy      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ovf   <= w_ovf;
      if (w_claim) begin
        r_fill_bank   <= w_bank;
        r_hdr[w_bank] <= bus.hdr_in;
        r_bst[w_bank] <= B_FILL;
        r_wr_cnt      <= 11'd1;
      end else if (w_done) begin
        r_bst[r_fill_bank] <= B_FULL;
        r_wr_bank          <= ~r_fill_bank;
        r_wr_cnt           <= 11'd0;
      end else if (w_we) begin
        r_wr_cnt <= r_wr_cnt + 11'd1;
      end
      // Reader only touches FULL/READ banks, writer only FREE/FILL
      if (w_ack_start) begin
        r_bst[r_rd_bank] <= B_READ;
        r_busy           <= 1'b1;
      end
      if (w_ack_end) begin
        r_bst[r_rd_bank] <= B_FREE;
        r_busy           <= 1'b0;
        r_rd_bank        <= ~r_rd_bank;
      end
      if (bus.ap_ack && r_ap_req)
        r_ap_req <= 1'b0;
      else if (r_bst[r_rd_bank] == B_FULL && !r_busy)
        r_ap_req <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we)
      r_mem[{w_bank, w_waddr}] <= {bus.din_di, bus.din_dr};
    r_rdat <= r_mem[{r_rbank, r_raddr}];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raddr   <= 11'd0;
      r_rbank   <= 1'b0;
      r_ren1    <= 1'b0;
      r_ren2    <= 1'b0;
      r_rd_data <= 32'd0;
    end else begin
      r_raddr   <= bus.rd_addr;
      r_rbank   <= r_rd_bank;
      r_ren1    <= bus.rd_en;
      r_ren2    <= r_ren1;
      r_rd_data <= r_ren2 ? r_rdat : 32'd0;
    end
  end

`ifdef PRACH_ANT_BUFFER_OVF_CNT_EN
  logic [15:0] r_ovf_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ovf_cnt <= 16'd0;
    else if (r_ovf && r_ovf_cnt != 16'hFFFF)
      r_ovf_cnt <= r_ovf_cnt + 16'd1;
  end

  assign bus.ovf_cnt = r_ovf_cnt;
`endif

  assign bus.ap_hdr  = r_hdr[r_rd_bank];
  assign bus.ap_req  = r_ap_req;
  assign bus.rd_data = r_rd_data;
  assign bus.ovf     = r_ovf;

endmodule
